// File: rtl/motor_cmd_arbiter.sv
// Fixed-priority arbiter for the shared two-motor drive with preemption, minimum hold and H-bridge dead-time.
// Optional power soft-start ramp is enabled by defining SOFTSTART_EN.
module motor_cmd_arbiter #(
  parameter int DEADTIME = 4,
  parameter int MIN_HOLD = 8,
  parameter int RAMP_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [11:0] req_dir,
  input  logic [8:0]  req_pwr,
  output logic [2:0]  grant,
  output logic [3:0]  dir_out,
  output logic [2:0]  pwr_l,
  output logic [2:0]  pwr_r,
  output logic        busy
);

  // Handshake: req_valid[i] is a level request; the arbiter answers with a
  // registered one-hot grant, and a requester owns the drive while its grant bit is high.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_INIT = 8'(MIN_HOLD);
  localparam logic [7:0] DT_INIT   = 8'(DEADTIME);
  localparam logic [1:0] NONE      = 2'd3;

  if (RAMP_DIV < 1) begin : g_ramp_div_range
  end

  function automatic logic [3:0] norm_dir(input logic [3:0] d);
    case (d)
      4'b1001, 4'b0110, 4'b0101, 4'b1010: norm_dir = d;
      default:                            norm_dir = 4'b0000;
    endcase
  endfunction

  // A reversal or turn change needs dead-time only between two distinct moving codes.
  function automatic logic is_rev(input logic [3:0] a, input logic [3:0] b);
    is_rev = (a != 4'b0000) && (b != 4'b0000) && (a != b);
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] gate_pwr(input logic [3:0] d, input logic [2:0] p);
    gate_pwr = (d == 4'b0000) ? 3'd0 : p;
  endfunction

  // Registered state, visible to bound checkers as state_q.
  state_t     state_q, state_n;
  logic [1:0] owner_q, owner_n;
  logic [1:0] pend_q, pend_n;
  logic [7:0] hold_q, hold_n;
  logic [7:0] dt_q, dt_n;
  logic [3:0] last_q, last_n;

  logic [2:0] grant_n;
  logic [3:0] dir_n;
  logic [2:0] pwr_n;
  logic       busy_n;

  logic [3:0] dir_v [4];
  logic [2:0] pwr_v [4];
  logic [3:0] valid4;
  logic [1:0] win;
  logic       take;
  logic       check_rev;
  logic [1:0] take_idx;

  assign dir_v[0] = norm_dir(req_dir[3:0]);
  assign dir_v[1] = norm_dir(req_dir[7:4]);
  assign dir_v[2] = norm_dir(req_dir[11:8]);
  assign dir_v[3] = 4'b0000;
  assign pwr_v[0] = req_pwr[2:0];
  assign pwr_v[1] = req_pwr[5:3];
  assign pwr_v[2] = req_pwr[8:6];
  assign pwr_v[3] = 3'd0;
  assign valid4   = {1'b0, req_valid};

  always_comb begin
    if (req_valid[0])      win = 2'd0;
    else if (req_valid[1]) win = 2'd1;
    else if (req_valid[2]) win = 2'd2;
    else                   win = NONE;
  end

  always_comb begin
    state_n   = state_q;
    owner_n   = owner_q;
    pend_n    = pend_q;
    hold_n    = hold_q;
    dt_n      = dt_q;
    last_n    = last_q;
    grant_n   = 3'b000;
    dir_n     = 4'b0000;
    pwr_n     = 3'd0;
    busy_n    = 1'b0;
    take      = 1'b0;
    take_idx  = win;
    check_rev = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        last_n = 4'b0000;
        if (win != NONE) begin
          take      = 1'b1;
          check_rev = 1'b0;
        end
      end

      ST_DRIVE: begin
        hold_n = (hold_q == 8'd0) ? 8'd0 : hold_q - 8'd1;
        if (win < owner_q) begin
          take = 1'b1;
        end else if (valid4[owner_q]) begin
          if (is_rev(last_q, dir_v[owner_q])) begin
            // Owner keeps the drive across its own reversal via pending.
            state_n = ST_DEAD;
            pend_n  = owner_q;
            dt_n    = DT_INIT;
            busy_n  = 1'b1;
          end else begin
            grant_n = onehot(owner_q);
            dir_n   = dir_v[owner_q];
            pwr_n   = gate_pwr(dir_v[owner_q], pwr_v[owner_q]);
            last_n  = dir_v[owner_q];
          end
        end else if (hold_q != 8'd0) begin
          grant_n = onehot(owner_q);
        end else if (win != NONE) begin
          take = 1'b1;
        end else begin
          state_n = ST_IDLE;
          last_n  = 4'b0000;
        end
      end

      ST_DEAD: begin
        pend_n = (win < pend_q) ? win : pend_q;
        if (dt_q > 8'd1) begin
          dt_n   = dt_q - 8'd1;
          busy_n = 1'b1;
        end else begin
          dt_n      = 8'd0;
          check_rev = 1'b0;
          if (valid4[pend_n]) begin
            take     = 1'b1;
            take_idx = pend_n;
          end else if (win != NONE) begin
            take = 1'b1;
          end else begin
            state_n = ST_IDLE;
            last_n  = 4'b0000;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase

    if (take) begin
      if (check_rev && is_rev(last_q, dir_v[take_idx])) begin
        state_n = ST_DEAD;
        pend_n  = take_idx;
        dt_n    = DT_INIT;
        busy_n  = 1'b1;
      end else begin
        state_n = ST_DRIVE;
        owner_n = take_idx;
        hold_n  = HOLD_INIT;
        grant_n = onehot(take_idx);
        dir_n   = dir_v[take_idx];
        pwr_n   = gate_pwr(dir_v[take_idx], pwr_v[take_idx]);
        last_n  = dir_v[take_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      pend_q  <= 2'd0;
      hold_q  <= 8'd0;
      dt_q    <= 8'd0;
      last_q  <= 4'b0000;
      grant   <= 3'b000;
      dir_out <= 4'b0000;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      owner_q <= owner_n;
      pend_q  <= pend_n;
      hold_q  <= hold_n;
      dt_q    <= dt_n;
      last_q  <= last_n;
      grant   <= grant_n;
      dir_out <= dir_n;
      busy    <= busy_n;
    end
  end

  logic [2:0] pwr_q;

`ifdef SOFTSTART_EN
  localparam logic [7:0] RAMP_LAST = 8'(RAMP_DIV - 1);
  logic [7:0] ramp_q;

  // Stop and dead-time clear power at once; otherwise step one level per RAMP_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwr_q  <= 3'd0;
      ramp_q <= 8'd0;
    end else if (dir_n == 4'b0000) begin
      pwr_q  <= 3'd0;
      ramp_q <= 8'd0;
    end else if (pwr_q == pwr_n) begin
      ramp_q <= 8'd0;
    end else if (ramp_q == RAMP_LAST) begin
      ramp_q <= 8'd0;
      pwr_q  <= (pwr_q < pwr_n) ? pwr_q + 3'd1 : pwr_q - 3'd1;
    end else begin
      ramp_q <= ramp_q + 8'd1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) pwr_q <= 3'd0;
    else       pwr_q <= pwr_n;
  end
`endif

  assign pwr_l = pwr_q;
  assign pwr_r = pwr_q;

endmodule

// File: doc/motor_cmd_arbiter.md
Name: motor_cmd_arbiter

Overview:
- Shares the two-motor drive (direction nibble plus left/right PWM power levels) among three command sources: deadend/safety handler, beacon handler and line follower.
- Uses fixed priority with preemption and a minimum ownership time.
- Inserts an H-bridge dead-time (outputs stopped) on every reversal or turn change.
- Sits between the navigation state machines and the per-motor pwm instances.

Parameters:
- DEADTIME, 4, cycles of forced stop between two different non-stop directions (1..255).
- MIN_HOLD, 8, minimum cycles an owner keeps the drive before equal/lower priority can take it (1..255).
- RAMP_DIV, 16, cycles per power step; used only when SOFTSTART_EN is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  3  per-requester request; bit0 = safety (highest), bit1 = beacon, bit2 = line follower (lowest)
- req_dir  in  12  direction codes, [3:0] req0, [7:4] req1, [11:8] req2
- req_pwr  in  9  power level 0..7, [2:0] req0, [5:3] req1, [8:6] req2
- grant  out  3  one-hot current owner; 0 when idle or in dead-time
- dir_out  out  4  applied direction; [1:0] to left bridge, [3:2] to right bridge
- pwr_l  out  3  left motor power level to pwm
- pwr_r  out  3  right motor power level to pwm
- busy  out  1  high in DEADTIME state

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All outputs are registered.
- Reset values: grant=0, dir_out=0000 (stop), pwr_l=0, pwr_r=0, busy=0, state IDLE, counters 0.
- Direction codes:
  - forward 1001, backward 0110, left 0101, right 1010, stop 0000.
  - Any other code is treated as stop.
  - pwr_l = pwr_r = req_pwr of the owner; power is forced 0 whenever the applied direction is stop.
- Winner each cycle: the lowest-index asserted req_valid bit.
- IDLE:
  - Outputs stop, grant=0.
  - If any request is valid: latch the winner, go to DRIVE, load hold_cnt=MIN_HOLD.
  - Outputs reflect the winner the cycle after req_valid rises (latency 1).
- DRIVE:
  - Owner's current req_dir/req_pwr are re-sampled every cycle while it stays owner.
  - hold_cnt decrements to 0 and saturates there.
- Switch conditions, evaluated every cycle in DRIVE:
  - (a) A higher-priority requester becomes valid: switch at any time, ignoring hold_cnt.
  - (b) Owner drops valid with hold_cnt==0: switch to the next winner, or go to IDLE if none is valid.
  - (c) Owner drops valid with hold_cnt>0: outputs go stop/0 while grant is kept; re-evaluate when hold_cnt reaches 0. A higher-priority request still preempts immediately.
  - (d) Owner's own dir change between two different non-stop codes is also a switch and goes through DEADTIME; grant is held.
- Switch path:
  - If both old and new directions are non-stop and differ: go to DEADTIME, pending = new winner, dt_cnt=DEADTIME.
  - Otherwise: go directly to DRIVE, reload hold_cnt=MIN_HOLD.
- DEADTIME:
  - Outputs stop, pwr 0, grant=0, busy=1; dt_cnt decrements.
  - A higher-priority request arriving replaces pending; the counter does not restart.
  - At dt_cnt==0: if pending is still valid, go to DRIVE with it (hold_cnt=MIN_HOLD); else re-arbitrate (DRIVE or IDLE).
  - Exact stop duration is DEADTIME cycles.
- Simultaneous events: preemption and owner release in the same cycle resolve as preemption. Multiple new requests resolve by priority only; there is no fairness.
- Reset mid-operation: immediate return to reset values on the next edge, including from DEADTIME; no pending state survives.

Optional Feature:
- Macro: SOFTSTART_EN.
- Defined:
  - pwr_l/pwr_r step by ±1 toward the target every RAMP_DIV cycles.
  - Power is still forced to 0 instantly on stop and on DEADTIME entry.
  - After DEADTIME, power ramps up from 0.
- Undefined: power equals the target the cycle after it is sampled; no ramp counter exists.

Test Plan:
- Reset, then req_valid=100 with dir 1001, pwr 2 -> next cycle grant=100, dir_out=1001, pwr_l=pwr_r=2; with reset held, all outputs 0.
- Owner req2 forward, then req0 asserts backward 0110 at cycle 3 -> grant=0 and busy=1 for exactly 4 cycles with dir_out=0000, then grant=001 and dir_out=0110.
- Owner req1 left 0101; req2 asserts right 1010 at cycle 2 and req1 drops at cycle 2 -> dir_out 0000, grant stays 010 until hold expires (cycle 8). Then 4 dead-time cycles, then grant=100 with dir_out=1010.
- During DEADTIME (pending req2), req1 asserts forward at dt_cnt=2 -> after 2 more cycles grant=010, dir_out=1001; total stop stays 4 cycles.
- Owner dir 1111 (invalid) -> dir_out=0000, pwr 0; then switching to 1001 skips dead-time (latency 1).
- SOFTSTART_EN, RAMP_DIV=16, target pwr 5 from idle -> pwr_l steps 1,2,3,4,5 at 16-cycle intervals; stop request -> 0 on the next cycle.
